// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the fetch stage: word type, IF/ID register control and address wrapping.
package fetch_stage_pkg;

   typedef logic [31:0] word_t;

   localparam word_t DEF_RESET_PC   = 32'h0000_0000;
   localparam int    DEF_IMEM_BYTES = 256;
   localparam word_t DEF_NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [1:0] {
      IFID_LOAD   = 2'd0,
      IFID_HOLD   = 2'd1,
      IFID_BUBBLE = 2'd2
   } ifid_ctl_e;

   // Confine a byte address to the instruction memory and force word alignment.
   function automatic word_t wrap_addr(input word_t addr, input word_t mask);
      return addr & mask & ~word_t'(3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: instruction memory, pipeline control and IF/ID outputs.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   word_t imem_addr;
   word_t imem_instr;
   logic  stall;
   logic  flush;
   logic  redirect_valid;
   word_t redirect_target;
   logic  if_id_valid;
   word_t if_id_instr;
   word_t if_id_pc;
   word_t if_id_pc4;
   logic  misalign_err;
   word_t fetch_count;

   modport master (
      input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, misalign_err, fetch_count,
      output imem_instr, stall, flush, redirect_valid, redirect_target
   );

   modport slave (
      output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, misalign_err, fetch_count,
      input  imem_instr, stall, flush, redirect_valid, redirect_target
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register between fetch and decode with bubble / hold / load control.
module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic      clk,
   input  logic      rst,
   input  ifid_ctl_e ctl,
   input  word_t     instr_in,
   input  word_t     pc_in,
   input  word_t     pc4_in,
   output logic      valid,
   output word_t     instr,
   output word_t     pc,
   output word_t     pc4
);

   logic  valid_reg;
   word_t instr_reg;
   word_t pc_reg;
   word_t pc4_reg;

   always_ff @(posedge clk) begin
      if (rst || ctl == IFID_BUBBLE) begin
         valid_reg <= 1'b0;
         instr_reg <= NOP_INSTR;
         pc_reg    <= '0;
         pc4_reg   <= '0;
      end else if (ctl == IFID_LOAD) begin
         valid_reg <= 1'b1;
         instr_reg <= instr_in;
         pc_reg    <= pc_in;
         pc4_reg   <= pc4_in;
      end
   end

   assign valid = valid_reg;
   assign instr = instr_reg;
   assign pc    = pc_reg;
   assign pc4   = pc4_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, misalignment flag and fetch counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC   = DEF_RESET_PC,
   parameter int    IMEM_BYTES = DEF_IMEM_BYTES,
   parameter word_t NOP_INSTR  = DEF_NOP_INSTR
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.slave  bus
);

   localparam word_t ADDR_MASK = word_t'(IMEM_BYTES - 1);

   word_t     pc_reg;
   word_t     pc_next;
   word_t     seq_pc;
   logic      misalign_reg;
   logic      misalign_next;
   word_t     fetch_count_reg;
   ifid_ctl_e ifid_ctl;

   always_comb begin
      seq_pc = wrap_addr(pc_reg + 32'd4, ADDR_MASK);
      pc_next = seq_pc;
      if (bus.redirect_valid) begin
         pc_next = wrap_addr(bus.redirect_target, ADDR_MASK);
      end else if (bus.stall) begin
         pc_next = pc_reg;
      end
   end

   // A redirect discards whatever was fetched this cycle, even while stalled.
   always_comb begin
      ifid_ctl = IFID_LOAD;
      if (bus.flush || bus.redirect_valid) begin
         ifid_ctl = IFID_BUBBLE;
      end else if (bus.stall) begin
         ifid_ctl = IFID_HOLD;
      end
   end

   assign misalign_next = misalign_reg | (bus.redirect_valid & (|bus.redirect_target[1:0]));

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= RESET_PC;
         misalign_reg    <= 1'b0;
         fetch_count_reg <= '0;
      end else begin
         pc_reg       <= pc_next;
         misalign_reg <= misalign_next;
         if (ifid_ctl == IFID_LOAD) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
         end
      end
   end

   fetch_stage_if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .ctl      (ifid_ctl),
      .instr_in (bus.imem_instr),
      .pc_in    (pc_reg),
      .pc4_in   (seq_pc),
      .valid    (bus.if_id_valid),
      .instr    (bus.if_id_instr),
      .pc       (bus.if_id_pc),
      .pc4      (bus.if_id_pc4)
   );

   assign bus.imem_addr    = pc_reg;
   assign bus.misalign_err = misalign_reg;
   assign bus.fetch_count  = fetch_count_reg;

endmodule
